// File: rtl/debounce_pkg.sv
// Shared front-panel debounce definitions.
// Contents:
//   - S_LOW / S_RISE_CHK / S_HIGH / S_FALL_CHK : 2-bit per-channel FSM state codes.
//     These values also appear on the state_dbg bus.
//   - DEF_STABLE_TICKS / DEF_LONG_TICKS : default qualification and long-press times,
//     counted in prescaler ticks.
//   - debounce_state_name : readable state name for messages.
package debounce_pkg;

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_RISE_CHK = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_FALL_CHK = 2'd3;

    localparam int DEF_STABLE_TICKS = 2;
    localparam int DEF_LONG_TICKS   = 10;

    function automatic string debounce_state_name(input logic [1:0] st);
        case (st)
            S_LOW:      return "S_LOW";
            S_RISE_CHK: return "S_RISE_CHK";
            S_HIGH:     return "S_HIGH";
            default:    return "S_FALL_CHK";
        endcase
    endfunction

endpackage

// File: rtl/debounce_tick_if.sv
// Front-panel debounce bus.
// Signals:
//   - tick        : shared prescaler tick (1-cycle pulse)
//   - btn_in      : raw asynchronous button inputs
//   - btn_level   : debounced level
//   - btn_press   : 1-cycle event pulse on an accepted press
//   - btn_release : 1-cycle event pulse on an accepted release
//   - btn_long    : 1-cycle event pulse on a long press
//   - state_dbg   : per-channel FSM state, 2 bits per channel.
//                   Channel i occupies bits [2*i +: 2].
// Modports:
//   - master : the side that drives tick and btn_in (prescaler / pads)
//   - slave  : the debouncer
// There is no valid/ready handshake on this bus.
// Every event output is a single-cycle pulse. The consumer must sample it on each clock.
interface debounce_tick_if #(
    parameter int N = 4
);
    logic           tick;
    logic [N-1:0]   btn_in;
    logic [N-1:0]   btn_level;
    logic [N-1:0]   btn_press;
    logic [N-1:0]   btn_release;
    logic [N-1:0]   btn_long;
    logic [2*N-1:0] state_dbg;

    modport master (
        output tick, btn_in,
        input  btn_level, btn_press, btn_release, btn_long, state_dbg
    );

    modport slave (
        input  tick, btn_in,
        output btn_level, btn_press, btn_release, btn_long, state_dbg
    );
endinterface

// File: rtl/debounce_chan.sv
// Single-channel debouncer. The channel contains:
//   - a 2-FF synchroniser,
//   - a 4-state qualification FSM,
//   - a stability counter (stab_cnt),
//   - a hold counter (hold_cnt).
//
// Ports:
//   - clk, rst_n    : clock; synchronous reset, active low
//   - tick          : shared prescaler tick
//   - btn_in        : raw asynchronous input
//   - btn_level     : debounced level
//   - btn_press     : 1-cycle pulse, registered
//   - btn_release   : 1-cycle pulse, registered
//   - btn_long      : 1-cycle pulse, registered
//   - state_dbg     : current FSM state
//
// Priority rule:
//   If the synchronised input changes in the same cycle as a tick, the state change wins.
//   That tick is not counted by this channel.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       btn_long,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_CNT  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    always_comb begin
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            S_LOW: begin
                if (sync2_q) begin
                    state_d = S_RISE_CHK;
                    stab_d  = '0;
                end
            end
            S_RISE_CHK: begin
                if (!sync2_q) begin
                    state_d = S_LOW;
                end else if (tick) begin
                    if (stab_q == STAB_LAST) begin
                        state_d = S_HIGH;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hold_d  = '0;
                        stab_d  = '0;
                    end else begin
                        stab_d = stab_q + CNT_W'(1);
                    end
                end
            end
            S_HIGH: begin
                if (!sync2_q) begin
                    state_d = S_FALL_CHK;
                    stab_d  = '0;
                end else if (tick && LONG_TICKS != 0 && hold_q < LONG_CNT) begin
                    // hold_cnt saturates, so btn_long fires only once per press
                    hold_d = hold_q + CNT_W'(1);
                    long_d = (hold_q == LONG_LAST);
                end
            end
            S_FALL_CHK: begin
                if (sync2_q) begin
                    // Bounce back: hold_cnt is preserved, so a fired long cannot re-fire.
                    state_d = S_HIGH;
                end else if (tick) begin
                    if (stab_q == STAB_LAST) begin
                        state_d   = S_LOW;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        hold_d    = '0;
                        stab_d    = '0;
                    end else begin
                        stab_d = stab_q + CNT_W'(1);
                        // The button still counts as held until the release is accepted.
                        if (LONG_TICKS != 0 && hold_q < LONG_CNT) begin
                            hold_d = hold_q + CNT_W'(1);
                            long_d = (hold_q == LONG_LAST);
                        end
                    end
                end
            end
            default: state_d = S_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= S_LOW;
            stab_q    <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign state_dbg   = state_q;

endmodule

// File: rtl/debounce_tick.sv
// Multi-channel button/switch debouncer.
// Structure:
//   - One debounce_chan instance per input.
//   - All channels share the external prescaler tick.
//   - This block generates no tick of its own.
// Ports:
//   - clk, rst_n : clock; synchronous reset, active low
//   - bus        : debounce_tick_if slave modport, carrying:
//                    tick, btn_in, btn_level, btn_press, btn_release, btn_long, state_dbg
// Parameters:
//   - NUM_INPUTS must match the N parameter of the connected interface.
module debounce_tick
    import debounce_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int CNT_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    debounce_tick_if.slave  bus
);

    logic [NUM_INPUTS-1:0]   level_w;
    logic [NUM_INPUTS-1:0]   press_w;
    logic [NUM_INPUTS-1:0]   release_w;
    logic [NUM_INPUTS-1:0]   long_w;
    logic [2*NUM_INPUTS-1:0] state_w;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (bus.tick),
            .btn_in      (bus.btn_in[i]),
            .btn_level   (level_w[i]),
            .btn_press   (press_w[i]),
            .btn_release (release_w[i]),
            .btn_long    (long_w[i]),
            .state_dbg   (state_w[2*i +: 2])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_long    = long_w;
    assign bus.state_dbg   = state_w;

endmodule

// File: tb/tb_debounce_tick.sv
module tb_debounce_tick;
    import debounce_pkg::*;

    localparam int N      = 4;
    localparam int STABLE = 2;
    localparam int LONG   = 5;
    localparam int TPER   = 8;

    logic clk;
    logic rst_n;

    debounce_tick_if #(.N(N)) bus ();

    debounce_tick #(
        .NUM_INPUTS   (N),
        .STABLE_TICKS (STABLE),
        .LONG_TICKS   (LONG),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int tick_ph  = 0;
    int tick_total = 0;
    int cyc_cnt  = 0;
    int cnt_press[N];
    int cnt_release[N];
    int cnt_long[N];
    int last_press_tick;
    int last_long_tick;

    // reference model: works on accepted levels and on tick counts since the last input change
    logic [N-1:0] m_sh1, m_sh2, m_prev;
    logic [N-1:0] exp_level, exp_press, exp_release, exp_long;
    int           m_run[N];
    int           m_hold[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
    endtask

    task automatic model_step(input logic rst, input logic tk, input logic [N-1:0] din);
        logic [N-1:0] s;
        logic chg, was_high, rel_now;
        exp_press   = '0;
        exp_release = '0;
        exp_long    = '0;
        if (!rst) begin
            m_sh1 = '0; m_sh2 = '0; m_prev = '0; exp_level = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0;
                m_hold[i] = 0;
            end
        end else begin
            s = m_sh2;
            for (int i = 0; i < N; i++) begin
                chg      = (s[i] != m_prev[i]);
                was_high = exp_level[i];
                rel_now  = 1'b0;
                if (s[i] != exp_level[i]) begin
                    if (chg) m_run[i] = 0;
                    else if (tk) begin
                        m_run[i]++;
                        if (m_run[i] == STABLE) begin
                            m_run[i] = 0;
                            m_hold[i] = 0;
                            exp_level[i] = s[i];
                            if (s[i]) exp_press[i] = 1'b1;
                            else begin
                                exp_release[i] = 1'b1;
                                rel_now = 1'b1;
                            end
                        end
                    end
                end
                if (was_high && tk && !chg && !rel_now && m_hold[i] < LONG) begin
                    m_hold[i]++;
                    if (m_hold[i] == LONG) exp_long[i] = 1'b1;
                end
            end
            m_prev = s;
            m_sh2  = m_sh1;
            m_sh1  = din;
        end
    endtask

    // driver: one clock cycle, starting and ending just after a negedge
    task automatic run_cycle();
        bus.tick = (tick_ph == TPER - 1);
        if (bus.tick) tick_total++;
        model_step(rst_n, bus.tick, bus.btn_in);
        @(negedge clk);
        check("btn_level",   bus.btn_level,   exp_level);
        check("btn_press",   bus.btn_press,   exp_press);
        check("btn_release", bus.btn_release, exp_release);
        check("btn_long",    bus.btn_long,    exp_long);
        for (int i = 0; i < N; i++) begin
            cnt_press[i]   += int'(bus.btn_press[i]);
            cnt_release[i] += int'(bus.btn_release[i]);
            cnt_long[i]    += int'(bus.btn_long[i]);
        end
        if (bus.btn_press != '0) last_press_tick = tick_total;
        if (bus.btn_long != '0) last_long_tick = tick_total;
        cyc_cnt++;
        tick_ph = (tick_ph + 1) % TPER;
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    task automatic wait_ph(input int p);
        for (int k = 0; k < TPER && tick_ph != p; k++) run_cycle();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0;
            cnt_release[i] = 0;
            cnt_long[i] = 0;
        end
    endtask

    initial begin : main
        int start_cyc, lat, press_cyc, tick_at_press;
        int dur[N];

        rst_n = 1'b0;
        bus.tick = 1'b0;
        bus.btn_in = 4'hF;

        // reset with inputs held high
        run_n(3);
        check("reset_state_dbg", bus.state_dbg, 8'h00);
        rst_n = 1'b1;
        clear_counts();
        run_n(2 * TPER + 3);
        for (int i = 0; i < N; i++) check("reset_release_press", cnt_press[i], 1);
        check("reset_release_level", bus.btn_level, 4'hF);
        bus.btn_in = 4'h0;
        run_n(30);
        check("all_released_level", bus.btn_level, 4'h0);

        // clean press on ch0
        clear_counts();
        bus.btn_in[0] = 1'b1;
        start_cyc = cyc_cnt;
        press_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            if (bus.btn_press[0] && press_cyc < 0) press_cyc = cyc_cnt - 1;
        end
        lat = press_cyc - start_cyc;
        check("clean_press_count", cnt_press[0], 1);
        check("clean_press_latency_ok", (lat >= 11 && lat <= 18), 1);
        check("clean_press_level", bus.btn_level[0], 1'b1);
        check("clean_press_no_release", cnt_release[0], 0);
        bus.btn_in[0] = 1'b0;
        run_n(30);

        // bouncing ch1
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            bus.btn_in[1] = ~bus.btn_in[1];
            run_n(3);
        end
        bus.btn_in[1] = 1'b0;
        run_n(30);
        check("bounce_no_press", cnt_press[1], 0);
        check("bounce_level", bus.btn_level[1], 1'b0);

        // ch2: press, glitch on release, then real release
        clear_counts();
        bus.btn_in[2] = 1'b1;
        run_n(30);
        check("ch2_pressed", cnt_press[2], 1);
        bus.btn_in[2] = 1'b0;
        run_n(5);
        bus.btn_in[2] = 1'b1;
        run_n(20);
        check("glitch_no_release", cnt_release[2], 0);
        check("glitch_level", bus.btn_level[2], 1'b1);
        bus.btn_in[2] = 1'b0;
        run_n(24);
        check("real_release", cnt_release[2], 1);
        check("real_release_level", bus.btn_level[2], 1'b0);
        run_n(10);

        // long press on ch3
        clear_counts();
        last_press_tick = 0;
        last_long_tick = 0;
        bus.btn_in[3] = 1'b1;
        run_n(60);
        tick_at_press = last_press_tick;
        check("long_press_count", cnt_press[3], 1);
        check("long_once", cnt_long[3], 1);
        check("long_tick_offset", last_long_tick - tick_at_press, LONG);
        run_n(40);
        check("long_no_refire", cnt_long[3], 1);
        bus.btn_in[3] = 1'b0;
        run_n(30);
        check("long_release", cnt_release[3], 1);

        // ch0 input drops in the very cycle its accepting tick arrives
        clear_counts();
        wait_ph(0);
        bus.btn_in[0] = 1'b1;
        run_n(13);
        bus.btn_in[0] = 1'b0;
        run_n(3);
        check("collision_state", bus.state_dbg[1:0], S_LOW);
        run_n(20);
        check("collision_no_press", cnt_press[0], 0);

        // reset while ch0 is held with hold_cnt = 3
        clear_counts();
        bus.btn_in[0] = 1'b1;
        tick_at_press = -1;
        for (int k = 0; k < 40 && cnt_press[0] == 0; k++) run_cycle();
        check("mid_hold_pressed", cnt_press[0], 1);
        tick_at_press = tick_total;
        for (int k = 0; k < 40 && tick_total < tick_at_press + 3; k++) run_cycle();
        check("mid_hold_ticks", tick_total - tick_at_press, 3);
        check("mid_hold_state", bus.state_dbg[1:0], S_HIGH);
        rst_n = 1'b0;
        bus.btn_in[0] = 1'b0;
        run_n(2);
        check("mid_hold_reset_outputs",
              {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long}, 16'h0);
        rst_n = 1'b1;
        run_n(50);
        check("mid_hold_no_long", cnt_long[0], 0);
        check("mid_hold_no_release", cnt_release[0], 0);

        // randomized mix of short bounces and long holds on all channels
        for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 40);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    bus.btn_in[i] = ~bus.btn_in[i];
                    dur[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(10, 70);
                end
            end
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
